// File: rtl/riscv_pkg.sv
// Shared definitions for the memory stage: load/store one-hot bit positions,
// the data-access FSM state encoding and the load-type priority resolver.
package riscv_pkg;

    localparam int LD_LB  = 0;
    localparam int LD_LBU = 1;
    localparam int LD_LH  = 2;
    localparam int LD_LHU = 3;
    localparam int LD_LW  = 4;

    localparam int ST_SB  = 0;
    localparam int ST_SH  = 1;
    localparam int ST_SW  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } dmem_state_e;

    // Collapses a possibly multi-hot load field to one hot bit: lw > lh > lhu > lb > lbu.
    function automatic logic [4:0] ld_resolve(input logic [4:0] ld);
        logic [4:0] r;
        r = '0;
        if (ld[LD_LW])       r[LD_LW]  = 1'b1;
        else if (ld[LD_LH])  r[LD_LH]  = 1'b1;
        else if (ld[LD_LHU]) r[LD_LHU] = 1'b1;
        else if (ld[LD_LB])  r[LD_LB]  = 1'b1;
        else if (ld[LD_LBU]) r[LD_LBU] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/dmem_access_unit_load_extend.sv
// Combinational byte/halfword/word extraction and sign/zero extension of a
// read word; shared with the writeback forwarding path.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [4:0]  i_ld_type,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data = '0;
        if (i_ld_type[LD_LW])       o_data = i_rdata;
        else if (i_ld_type[LD_LH])  o_data = {{16{w_half[15]}}, w_half};
        else if (i_ld_type[LD_LHU]) o_data = {16'h0000, w_half};
        else if (i_ld_type[LD_LB])  o_data = {{24{w_byte[7]}}, w_byte};
        else if (i_ld_type[LD_LBU]) o_data = {24'h00_0000, w_byte};
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage data access controller: one req/gnt (+rvalid for loads)
// transaction per access, lane-aligned stores, extended loads, pipeline stall.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned lh/lhu/sh/lw/sw with bus_err.
module dmem_access_unit
    import riscv_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwriteM,
    input  logic [4:0]  loadsrcM,
    input  logic [2:0]  StoreSrcM,
    input  logic [1:0]  AdrM,
    input  logic [31:0] aluresultM,
    input  logic [31:0] writeDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        stall_o,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_err,
    output logic [1:0]  o_dbg_state
);

    localparam logic [3:0] CNT_LAST = 4'(WAIT_MAX - 1);

    dmem_state_e r_state;
    dmem_state_e w_next_state;

    logic [3:0]  r_cnt;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [29:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic [4:0]  r_ld_type;
    logic [1:0]  r_off;
    logic [31:0] r_load_data;
    logic        r_load_valid;
    logic        r_bus_err;

    logic        w_active;
    logic        w_misalign;
    logic        w_timeout;
    logic        w_stall;
    logic [4:0]  w_ld_type;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ext_data;
    logic        w_unused;

    // The offset arrives separately as AdrM; the low address bits are redundant.
    assign w_unused = ^aluresultM[1:0];

    always_comb begin
        w_active  = memwriteM | (|loadsrcM);
        w_ld_type = memwriteM ? 5'd0 : ld_resolve(loadsrcM);
        w_timeout = (r_cnt == CNT_LAST);

        w_be    = 4'b1111;
        w_wdata = writeDataM;
        if (memwriteM && !StoreSrcM[ST_SW]) begin
            if (StoreSrcM[ST_SH]) begin
                w_be    = AdrM[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{writeDataM[15:0]}};
            end else if (StoreSrcM[ST_SB]) begin
                w_be    = 4'b0001 << AdrM;
                w_wdata = {4{writeDataM[7:0]}};
            end
        end

`ifdef MISALIGN_TRAP_EN
        if (memwriteM)
            w_misalign = (StoreSrcM[ST_SW] & (|AdrM)) |
                         (~StoreSrcM[ST_SW] & StoreSrcM[ST_SH] & AdrM[0]);
        else
            w_misalign = (w_ld_type[LD_LW] & (|AdrM)) |
                         ((w_ld_type[LD_LH] | w_ld_type[LD_LHU]) & AdrM[0]);
`else
        w_misalign = 1'b0;
`endif
    end

    // Next-state and stall; stall drops in DONE so EX/MEM can advance.
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_active) begin
                    w_stall      = 1'b1;
                    w_next_state = w_misalign ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (mem_gnt)        w_next_state = r_mem_we ? S_DONE : S_WAIT;
                else if (w_timeout) w_next_state = S_DONE;
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (mem_rvalid || w_timeout) w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    load_extend u_load_extend (
        .i_rdata   (mem_rdata),
        .i_off     (r_off),
        .i_ld_type (r_ld_type),
        .o_data    (w_ext_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
            r_ld_type    <= '0;
            r_off        <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_bus_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_active) begin
                        if (w_misalign) begin
                            r_bus_err <= 1'b1;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= memwriteM;
                            r_mem_addr  <= aluresultM[31:2];
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                            r_ld_type   <= w_ld_type;
                            r_off       <= AdrM;
                            r_cnt       <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        if (!r_mem_we) r_load_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_load_data  <= w_ext_data;
                        r_load_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_bus_err   <= 1'b1;
                        r_load_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_be      = r_mem_be;
    assign mem_wdata   = r_mem_wdata;
    assign stall_o     = w_stall;
    assign load_data   = r_load_data;
    assign load_valid  = r_load_valid;
    assign bus_err     = r_bus_err;
    assign o_dbg_state = r_state;

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage data access controller for the RISC-V pipeline. It consumes the memory-control fields delivered by the EX/MEM pipeline register: `memwriteM`, `StoreSrcM`, `loadsrcM`, `AdrM`, `aluresultM` and `writeDataM`. It runs one handshaked transaction per access with the data memory/cache. It produces byte-lane-aligned store data and sign/zero-extended load data, and stalls the pipeline while a transaction is outstanding.

## Interface
Parameters:
- `WAIT_MAX`, default 15: maximum cycles spent in any wait state before `bus_err` is raised (4-bit counter).

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `memwriteM`  in  1  store request.
- `loadsrcM`  in  5  one-hot load type: bit0 lb, bit1 lbu, bit2 lh, bit3 lhu, bit4 lw; 0 means no load.
- `StoreSrcM`  in  3  one-hot store type: bit0 sb, bit1 sh, bit2 sw.
- `AdrM`  in  2  byte offset, equal to `aluresultM[1:0]`.
- `aluresultM`  in  32  effective byte address.
- `writeDataM`  in  32  store source register value.
- `mem_req`  out  1  request valid.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  30  word address.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-aligned write data.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read word.
- `stall_o`  out  1  hold IF..EX/MEM registers.
- `load_data`  out  32  extended load result for writeback.
- `load_valid`  out  1  `load_data` valid, one-cycle pulse.
- `bus_err`  out  1  timeout, or misaligned access (see Configuration); one-cycle pulse.

## Operation
- An access is active when `memwriteM` is 1 or `loadsrcM` is nonzero. If both are set, the store wins and the load fields are ignored. A non-one-hot `loadsrcM` is resolved by priority lw > lh > lhu > lb > lbu.
- FSM states are IDLE, REQ, WAIT and DONE.
  - IDLE: on an active access, latch `mem_addr = aluresultM[31:2]`, the byte enables, the write data, and the load type/offset. Go to REQ.
  - REQ: `mem_req` = 1 with the latched fields. On `mem_gnt`, a store goes to DONE and a load goes to WAIT. `mem_rvalid` is ignored in REQ.
  - WAIT: on `mem_rvalid`, capture the extended data and go to DONE.
  - DONE: pulse `load_valid` (loads only). Return to IDLE; inputs are ignored in DONE.
- Byte enables and write data:
  - sb: `mem_be` = 0001 << `AdrM`; data is `writeDataM[7:0]` replicated to all 4 lanes.
  - sh: `mem_be` = 0011 << {`AdrM[1]`,0}; data is `writeDataM[15:0]` replicated to both halves.
  - sw: `mem_be` = 1111; data is `writeDataM` unchanged.
  - Loads: `mem_be` = 1111.
- Load extraction: select byte `mem_rdata[8*off +: 8]` or halfword `[16*off[1] +: 16]`. lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- `stall_o` = (IDLE and access active) or REQ or WAIT. It is low in DONE so EX/MEM advances.
- Timeout: a 4-bit counter clears on entry to REQ or WAIT and increments every cycle spent there. Reaching `WAIT_MAX` pulses `bus_err`, drops the transaction and goes to DONE with `load_data` = 0 and `load_valid` = 0.

## Timing
- Reset values:
  - `mem_req`, `mem_we`, `stall_o`, `load_valid`, `bus_err` are 0.
  - `mem_addr`, `mem_be`, `mem_wdata`, `load_data` are 0.
  - State is IDLE and the counter is 0.
- Reset asserted mid-transaction returns to IDLE asynchronously and drops `mem_req` immediately. Any pending read response is discarded.
- Store with `mem_gnt` on the first REQ cycle: 2 stall cycles, DONE in the 3rd cycle.
- Load with `mem_gnt` on the first REQ cycle and `mem_rvalid` one cycle later: 3 stall cycles; `load_valid` and `load_data` are high in the 4th cycle.
- `mem_req`, `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are registered and stay stable until `mem_gnt`.
- `load_data` holds its value until the next load completes.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - In IDLE, lh/lhu/sh with `AdrM[0]` = 1, or lw/sw with `AdrM` != 0, issues no request.
  - The FSM goes directly to DONE, pulses `bus_err`, and stalls for 1 cycle.
- `MISALIGN_TRAP_EN` undefined: no check is made. The offset bits that the rules above do not use are ignored, and the access proceeds normally.

## Structure
- Shared package `riscv_pkg`:
  - load one-hot bit indices;
  - store one-hot bit indices;
  - FSM state enum (2 bits).
- One sub-module, `load_extend`: combinational, taking `mem_rdata`, the offset and the load type and producing the 32-bit result. It is reused by writeback forwarding.

## Test plan
- sb at address 0x0000_0103 with `writeDataM` = 0x1234_56AB: `mem_be` = 1000, `mem_wdata` = 0xABAB_ABAB, `mem_addr` = 0x40, `stall_o` high for 2 cycles.
- lh at offset 2 with `mem_rdata` = 0x8001_7FFF: `load_data` = 0xFFFF_8001. lhu with the same inputs gives 0x0000_8001.
- lw with `mem_gnt` delayed 3 cycles and `mem_rvalid` delayed 2 more: `mem_req` held for 4 cycles with stable fields, then `load_valid` is pulsed once.
- No `mem_gnt` for 15 cycles: `bus_err` is pulsed, the FSM reaches IDLE, and `load_valid` stays 0.
- Reset asserted while in WAIT, and a late `mem_rvalid` arrives after reset: outputs are 0 immediately and `load_valid` never pulses.
- With `MISALIGN_TRAP_EN` defined, sw to 0x...02: no `mem_req`, `bus_err` pulses, `stall_o` is high for 1 cycle. Without the macro, `mem_be` = 1111 and `mem_addr` = address >> 2.
